timer_pulse_gen: RTL and testbench
==================================

TIMER_PULSE_GEN -- requirements
Module: timer_pulse_gen

Interface
REQ-001 SHALL provide parameter CW, default 8, width of period/high/burst/count fields.
REQ-002 SHALL provide port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port start  input  1  one-cycle request to begin a burst; honoured only in IDLE.
REQ-005 SHALL provide port stop  input  1  abort request; honoured in HIGH or LOW.
REQ-006 SHALL provide port period  input  CW  cycles per output pulse; sampled on accepted start.
REQ-007 SHALL provide port high_len  input  CW  cycles timer_out stays high per pulse; sampled on accepted start.
REQ-008 SHALL provide port burst  input  CW  number of pulses; 0 = continuous until stop; sampled on accepted start.
REQ-009 SHALL provide port timer_out  output  1  generated count pulse train for the downstream timer/counter T input.
REQ-010 SHALL provide port gate_out  output  1  high while a burst is active; drives the downstream gate/INTx window.
REQ-011 SHALL provide port busy  output  1  high in every state except IDLE.
REQ-012 SHALL provide port done  output  1  one-cycle pulse when a burst ends (complete or aborted).
REQ-013 SHALL provide port pulse_cnt  output  CW  number of pulses started in the current/last burst.

Function
REQ-014 SHALL implement states IDLE, HIGH, LOW, DONE; all outputs registered.
REQ-015 SHALL, in IDLE with start=1, latch period/high_len/burst, clear pulse_cnt, go to HIGH next cycle.
REQ-016 SHALL clamp latched period to minimum 2 and latched high_len to range 1..period-1.
REQ-017 SHALL drive timer_out=1 and gate_out=1 in HIGH, timer_out=0 and gate_out=1 in LOW.
REQ-018 SHALL assert timer_out exactly one cycle after the accepted start (latency 1).
REQ-019 SHALL hold HIGH for high_len cycles, then LOW for period-high_len cycles, using a CW-bit phase counter reset at each pulse start.
REQ-020 SHALL increment pulse_cnt on every HIGH entry; pulse_cnt saturates at all-ones in continuous mode.
REQ-021 SHALL, at the end of LOW, go to HIGH if burst=0 or pulse_cnt<burst, else to DONE.
REQ-022 SHALL, in DONE, assert done for one cycle with timer_out=0, gate_out=0, then return to IDLE.
REQ-023 SHALL, on stop=1 in HIGH or LOW, go to DONE next cycle, dropping timer_out and gate_out immediately (no partial-pulse stretch).
REQ-024 SHALL give stop priority over the LOW-end pulse continuation when both occur in the same cycle.
REQ-025 SHALL ignore start when not in IDLE and ignore stop in IDLE and DONE.
REQ-026 SHALL keep pulse_cnt stable from DONE until the next accepted start.
REQ-027 SHALL ignore changes on period/high_len/burst outside the accepted-start cycle.

Reset
REQ-028 SHALL, on rst_n=0, asynchronously enter IDLE with timer_out=0, gate_out=0, busy=0, done=0, pulse_cnt=0, all counters and latched fields 0.
REQ-029 SHALL, on reset mid-burst, abort without asserting done.
REQ-030 SHALL accept start on the first rising edge after rst_n deasserts.

Structure
REQ-031 SHALL place the state enumeration and default CW constant in shared package timer_pkg.
REQ-032 SHALL implement the phase counter as one sub-module pg_phase_cnt (load, decrement, zero flag); FSM in the top module.

Verification
REQ-033 Bench SHALL check: period=10, high_len=4, burst=3, start -> three pulses high 4 / low 6, gate_out high 30 cycles, done at cycle 31, pulse_cnt=3.
REQ-034 Bench SHALL check: period=1, high_len=5, burst=2 -> clamped to period 2, high 1, alternating 1/0 for 4 cycles, then done.
REQ-035 Bench SHALL check: burst=0, period=4, high_len=2, stop after 9 cycles -> timer_out/gate_out low next cycle, done one cycle, pulse_cnt=3.
REQ-036 Bench SHALL check: start asserted while busy with different period -> ignored, original waveform unchanged.
REQ-037 Bench SHALL check: rst_n low mid-HIGH -> all outputs 0 asynchronously, no done pulse, next start after release accepted.
REQ-038 Bench SHALL check: stop coincident with last LOW cycle of burst=5 pulse 2 -> DONE, pulse_cnt=2, no third pulse.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer pulse generator.
// Holds the default field width and the controller state encoding used by
// timer_pulse_gen and its phase counter.
package timer_pkg;

  // Default width of the period / high-length / burst / pulse-count fields.
  localparam int unsigned TIMER_CW_DEFAULT = 8;

  // Pulse generator controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } timer_state_e;

endpackage : timer_pkg

// File: rtl/pg_phase_cnt.sv
// Phase counter for the pulse generator.
// Loads a value, counts it down to zero and reports when it has reached zero.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   i_load     load i_load_val this cycle (takes priority over decrement)
//   i_load_val value to load (cycles remaining in the phase minus one)
//   i_dec      decrement by one; holds at zero
//   o_zero     counter is zero: current cycle is the last of the phase
module pg_phase_cnt #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  // Phase count register: load, decrement toward zero, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != {CW{1'b0}})) begin
      r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_zero = (r_cnt == {CW{1'b0}});

endmodule : pg_phase_cnt

// File: rtl/timer_pulse_gen.sv
// Timer pulse generator: emits a burst of pulses (or a continuous train) for a
// downstream timer/counter T input, with a gate window around the burst.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a burst (only accepted when idle)
//   stop                abort a running burst (HIGH or LOW phase)
//   period, high_len    pulse period and high time in cycles, sampled on start
//   burst               pulse count, 0 = run until stop, sampled on start
//   timer_out           pulse train
//   gate_out            high while the burst is running
//   busy                high whenever not idle
//   done                one-cycle pulse at the end of a burst
//   pulse_cnt           pulses started in the current/last burst
module timer_pulse_gen
  import timer_pkg::*;
#(
  parameter int unsigned CW = TIMER_CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic [CW-1:0] period,
  input  logic [CW-1:0] high_len,
  input  logic [CW-1:0] burst,
  output logic          timer_out,
  output logic          gate_out,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] pulse_cnt
);

  localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] TWO  = {{(CW-2){1'b0}}, 2'b10};
  localparam logic [CW-1:0] ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] ONES = {CW{1'b1}};

  timer_state_e  r_state;
  logic [CW-1:0] r_period;
  logic [CW-1:0] r_high_len;
  logic [CW-1:0] r_burst;
  logic [CW-1:0] r_pulse_cnt;
  logic          r_timer_out;
  logic          r_gate_out;
  logic          r_busy;
  logic          r_done;

  logic [CW-1:0] w_period_c;
  logic [CW-1:0] w_high_c;
  logic [CW-1:0] w_low_len;
  logic [CW-1:0] w_cnt_inc;
  logic          w_more;
  logic          w_load;
  logic [CW-1:0] w_load_val;
  logic          w_dec;
  logic          w_zero;

  // Field clamping and next-pulse decision helpers.
  always_comb begin
    w_period_c = (period < TWO) ? TWO : period;
    if (high_len == ZERO) begin
      w_high_c = ONE;
    end else if (high_len >= w_period_c) begin
      w_high_c = w_period_c - ONE;
    end else begin
      w_high_c = high_len;
    end
    w_low_len = r_period - r_high_len;
    w_cnt_inc = (r_pulse_cnt == ONES) ? r_pulse_cnt : (r_pulse_cnt + ONE);
    w_more    = (r_burst == ZERO) || (r_pulse_cnt < r_burst);
  end

  // Phase counter control: load at each phase start, otherwise count down.
  // The load value is the phase length minus one so o_zero marks the last cycle.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = ZERO;
    w_dec      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load     = 1'b1;
          w_load_val = w_high_c - ONE;
        end else begin
          w_load = 1'b0;
        end
      end
      ST_HIGH: begin
        if (stop) begin
          w_dec = 1'b0;
        end else if (w_zero) begin
          w_load     = 1'b1;
          w_load_val = w_low_len - ONE;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_LOW: begin
        if (stop) begin
          w_dec = 1'b0;
        end else if (w_zero && w_more) begin
          w_load     = 1'b1;
          w_load_val = r_high_len - ONE;
        end else if (w_zero) begin
          w_dec = 1'b0;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_DONE: begin
        w_dec = 1'b0;
      end
      default: begin
        w_dec = 1'b0;
      end
    endcase
  end

  pg_phase_cnt #(.CW(CW)) u_phase (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // Controller FSM with registered outputs; stop wins over pulse continuation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_period    <= ZERO;
      r_high_len  <= ZERO;
      r_burst     <= ZERO;
      r_pulse_cnt <= ZERO;
      r_timer_out <= 1'b0;
      r_gate_out  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_HIGH;
            r_period    <= w_period_c;
            r_high_len  <= w_high_c;
            r_burst     <= burst;
            r_pulse_cnt <= ONE;  // cleared, then counted for the first pulse
            r_timer_out <= 1'b1;
            r_gate_out  <= 1'b1;
            r_busy      <= 1'b1;
          end
          r_done <= 1'b0;
        end
        ST_HIGH: begin
          if (stop) begin
            r_state     <= ST_DONE;
            r_timer_out <= 1'b0;
            r_gate_out  <= 1'b0;
            r_done      <= 1'b1;
          end else if (w_zero) begin
            r_state     <= ST_LOW;
            r_timer_out <= 1'b0;
          end
        end
        ST_LOW: begin
          if (stop || (w_zero && !w_more)) begin
            r_state     <= ST_DONE;
            r_timer_out <= 1'b0;
            r_gate_out  <= 1'b0;
            r_done      <= 1'b1;
          end else if (w_zero) begin
            r_state     <= ST_HIGH;
            r_timer_out <= 1'b1;
            r_pulse_cnt <= w_cnt_inc;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_timer_out <= 1'b0;
          r_gate_out  <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign timer_out = r_timer_out;
  assign gate_out  = r_gate_out;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pulse_cnt = r_pulse_cnt;

endmodule : timer_pulse_gen

// File: tb/tb_timer_pulse_gen.sv
// Self-checking bench for timer_pulse_gen. Expected outputs come from an
// arithmetic model of a burst: for cycle k after the accepted start, the
// pulse index is (k-1)/period and the pulse is high while (k-1)%period < high.
module tb_timer_pulse_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [7:0] period;
  logic [7:0] high_len;
  logic [7:0] burst;
  logic       timer_out;
  logic       gate_out;
  logic       busy;
  logic       done;
  logic [7:0] pulse_cnt;

  int n_vec = 0;
  int n_err = 0;

  timer_pulse_gen #(.CW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .period    (period),
    .high_len  (high_len),
    .burst     (burst),
    .timer_out (timer_out),
    .gate_out  (gate_out),
    .busy      (busy),
    .done      (done),
    .pulse_cnt (pulse_cnt)
  );

  always #5 clk = ~clk;

  // Observed vector: {timer_out, gate_out, busy, done, pulse_cnt}
  task automatic chk(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    obs = {timer_out, gate_out, busy, done, pulse_cnt};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
    end
  endtask

  function automatic int clamp_p(input int p);
    return (p < 2) ? 2 : p;
  endfunction

  function automatic int clamp_h(input int h, input int p);
    if (h < 1) return 1;
    else if (h >= p) return p - 1;
    else return h;
  endfunction

  function automatic int pulses_at(input int k, input int p);
    int c;
    c = (k - 1) / p + 1;
    return (c > 255) ? 255 : c;
  endfunction

  // Runs one burst from IDLE. Must be called just after a falling edge.
  // s = cycle during which stop is driven (0 = none); noise = random start
  // and field changes while busy, random stop while done/idle.
  task automatic run_burst(input string tag, input int p_in, input int h_in,
                           input int b_in, input int s, input bit noise);
    int p, h, total, endc, c_end, c;
    logic t, g, bz, d;
    p     = clamp_p(p_in);
    h     = clamp_h(h_in, p);
    total = (b_in == 0) ? 1000000 : b_in * p;
    endc  = (s != 0 && s <= total) ? s : total;
    c_end = pulses_at(endc, p);
    period   = 8'(p_in);
    high_len = 8'(h_in);
    burst    = 8'(b_in);
    start    = 1'b1;
    stop     = 1'b0;
    for (int k = 1; k <= endc + 2; k++) begin
      @(negedge clk);
      if (k <= endc) begin
        t = ((k - 1) % p) < h; g = 1'b1; bz = 1'b1; d = 1'b0;
        c = pulses_at(k, p);
      end else begin
        t = 1'b0; g = 1'b0; bz = (k == endc + 1); d = (k == endc + 1);
        c = c_end;
      end
      chk($sformatf("%s_c%0d", tag, k), {t, g, bz, d, 8'(c)});
      start = (noise && k <= endc + 1) ? 1'($urandom) : 1'b0;
      if (noise) begin
        period   = 8'($urandom);
        high_len = 8'($urandom);
        burst    = 8'($urandom);
      end
      if (k == s) stop = 1'b1;
      else if (noise && k > endc) stop = 1'($urandom);
      else stop = 1'b0;
    end
    start = 1'b0;
  endtask

  initial begin
    int p, b, s;
    rst_n = 1'b1; start = 1'b0; stop = 1'b0;
    period = 8'd0; high_len = 8'd0; burst = 8'd0;
    #1 rst_n = 1'b0;
    #2 chk("reset", 12'h000);
    @(negedge clk);
    @(negedge clk);
    chk("reset_hold", 12'h000);
    rst_n = 1'b1;

    // Start on the first edge after reset release; 3 pulses of 4 high / 6 low
    run_burst("p10h4b3", 10, 4, 3, 0, 1'b0);
    // Clamped: period 2, high 1
    run_burst("clamp", 1, 5, 2, 0, 1'b0);
    // Continuous, stopped during cycle 9
    run_burst("cont_stop", 4, 2, 0, 9, 1'b0);
    // Start/field changes while busy must be ignored
    run_burst("start_busy", 10, 4, 3, 0, 1'b1);
    // Stop coincident with last LOW cycle of pulse 2
    run_burst("stop_lowend", 6, 2, 5, 12, 1'b0);
    // Pulse count saturation in continuous mode
    run_burst("sat", 2, 1, 0, 530, 1'b0);

    // Reset while HIGH: outputs drop at once, no done, restart accepted
    period = 8'd10; high_len = 8'd4; burst = 8'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("pre_rst_c1", {1'b1, 1'b1, 1'b1, 1'b0, 8'd1});
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 12'h000);
    @(negedge clk); chk("rst_nodone1", 12'h000);
    @(negedge clk); chk("rst_nodone2", 12'h000);
    rst_n = 1'b1;
    run_burst("after_rst", 5, 2, 2, 0, 1'b0);

    // Randomized bursts with input noise
    for (int i = 0; i < 20; i++) begin
      p = int'($urandom_range(0, 12));
      b = int'($urandom_range(0, 4));
      if (b == 0) s = int'($urandom_range(1, 40));
      else if ($urandom_range(0, 2) == 0) s = int'($urandom_range(1, b * clamp_p(p)));
      else s = 0;
      run_burst($sformatf("rnd%0d", i), p, int'($urandom_range(0, 12)), b, s, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_timer_pulse_gen
